sb_drain_arbiter: RTL and testbench
===================================

SB_DRAIN_ARBITER -- requirements
Module: sb_drain_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4; maximum consecutive load grants while a store drain is waiting.
REQ-002 Clk  in  1  sole clock; all state changes on the rising edge.
REQ-003 Rest  in  1  reset; synchronous, active-low.
REQ-004 ArbFlash  in  1  pipeline flush; cancels load traffic only.
REQ-005 SbReqAble/SbReqMat/SbReqPtr/SbReqAddr/SbReqDate  in  1/2/3/32/32  store-buffer drain request: valid, MAT, entry pointer (1..7), physical address, data.
REQ-006 SbGrant  out  1  pulse; the store buffer entry is accepted; entry moves to wait-commit.
REQ-007 SbBackAble/SbBackPtr  out  1/3  store write completed; entry pointer to free.
REQ-008 LdReqAble/LdReqMat/LdReqAddr/LdReqRobPtr  in  1/2/32/6  load access request.
REQ-009 LdGrant  out  1  pulse; the load request is accepted.
REQ-010 LdBackAble/LdBackDate/LdBackRobPtr  out  1/32/6  load data return.
REQ-011 DcReqAble/DcReqWrite/DcReqMat/DcReqAddr/DcReqDate  out  1/1/2/32/32  single shared Dcache port request.
REQ-012 DcReady  in  1  Dcache accepts the request this cycle.
REQ-013 DcBackAble/DcBackDate  in  1/32  Dcache completion; data is valid for reads only.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE and WAIT, with exactly one transaction outstanding at a time.
REQ-015 IDLE, store selection: the block SHALL select the store when SbReqAble=1 and SbReqPtr!=0, and either LdReqAble=0 or StarveCnt==STARVE_MAX.
REQ-016 IDLE, load selection: otherwise, when LdReqAble=1 and ArbFlash=0, the block SHALL select the load.
REQ-017 On selection in cycle N, the block SHALL assert SbGrant or LdGrant combinationally in cycle N, latch the request fields and the operation type into holding registers, and enter ISSUE at N+1.
REQ-018 SbReqAble with SbReqPtr==0 SHALL be ignored (no grant, no counter change).
REQ-019 ISSUE: DcReqAble=1 and the DcReq* outputs SHALL come from the holding registers; DcReqWrite=1 for a store; DcReqDate=0 for a load.
REQ-020 ISSUE: the block SHALL stay in ISSUE until DcReady=1, then enter WAIT.
REQ-021 WAIT: on DcBackAble, if the transaction is a store, the block SHALL pulse SbBackAble=1 with SbBackPtr set to the held pointer for one cycle, then return to IDLE.
REQ-022 WAIT: on DcBackAble, if the transaction is a load and Killed=0, the block SHALL pulse LdBackAble=1 with LdBackDate=DcBackDate and LdBackRobPtr set to the held value for one cycle, then return to IDLE.
REQ-023 The minimum store round trip SHALL be: grant at N, DcReqAble at N+1, and a new grant no earlier than the cycle after completion (one bubble in IDLE).
REQ-024 StarveCnt (3 bits) SHALL increment on each LdGrant while SbReqAble=1 and SbReqPtr!=0, and saturate at STARVE_MAX.
REQ-025 StarveCnt SHALL clear on SbGrant and SHALL hold in all other cycles.
REQ-026 ArbFlash in ISSUE with a load SHALL return the FSM to IDLE at the next edge; DcReqAble stays high during the flush cycle only if DcReady is also 1 that cycle, in which case the FSM enters WAIT with Killed=1.
REQ-027 ArbFlash in WAIT with a load SHALL set Killed; the completion is consumed with LdBackAble=0.
REQ-028 ArbFlash SHALL NOT affect a store transaction in any state; committed stores always complete.
REQ-029 ArbFlash in IDLE SHALL block load selection for that cycle only; store selection proceeds.
REQ-030 DcBackAble outside WAIT SHALL be ignored.
REQ-031 Killed SHALL clear on entry to IDLE.

Reset
REQ-032 With Rest=0 at an edge: the FSM SHALL go to IDLE, StarveCnt=0, Killed=0, and all holding registers SHALL be 0.
REQ-033 During reset all outputs SHALL be 0, including SbGrant and LdGrant, which are forced low while Rest=0.
REQ-034 Reset mid-transaction SHALL drop the transaction with no back pulse.

Structure
REQ-035 FSM state encodings, the STARVE_MAX default and the MAT width SHALL live in the shared define header alongside the existing bus widths.
REQ-036 The block SHALL be flat; no sub-module is required.

Verification
REQ-037 Store alone: SbReqAble=1, Ptr=3, Addr=0x1000, Date=0xDEAD → SbGrant at N; DcReqAble/DcReqWrite=1 at N+1; with DcReady at N+1 and DcBackAble at N+3 → SbBackAble=1, SbBackPtr=3 at N+3.
REQ-038 Contention: LdReqAble and SbReqAble (Ptr=5) both held high, zero-latency Dcache → 4 load grants, then 1 store grant; pattern repeats; StarveCnt reads 0 after each store grant.
REQ-039 Flush in WAIT: load granted, ArbFlash pulsed during WAIT, DcBackAble with Date=0x55 → LdBackAble stays 0; FSM returns to IDLE.
REQ-040 Flush on store: store Ptr=7 in ISSUE with DcReady held 0 for 3 cycles, ArbFlash pulsed → request persists; SbBackPtr=7 returned on completion.
REQ-041 Invalid pointer and reset: SbReqAble with Ptr=0 → no grant; Rest=0 asserted during WAIT → all outputs 0 and no back pulse.

Source files
------------

// File: rtl/sb_drain_arbiter_pkg.sv
// Shared definitions for the store-buffer drain / load arbiter.
//   - bus widths of the store-buffer, load and Dcache interfaces
//   - MAT width, default starvation limit and width of the starvation counter
//   - FSM state encoding
package sb_drain_arbiter_pkg;

  localparam int ADDR_W         = 32;
  localparam int DATA_W         = 32;
  localparam int SB_PTR_W       = 3;
  localparam int ROB_PTR_W      = 6;
  localparam int MAT_W          = 2;
  localparam int STARVE_CNT_W   = 3;
  localparam int STARVE_MAX_DEF = 4;

  // IDLE must stay at zero: the debug state output reads 0 during reset.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sb_drain_arbiter.sv
// Arbitrates the single shared Dcache port between store-buffer drains and
// load accesses, one transaction outstanding at a time.
//
// Ports
//   Clk, Rest            clock, synchronous active-low reset
//   ArbFlash             pipeline flush, cancels load traffic only
//   SbReq*               store drain request (pointer 0 means "no entry")
//   SbGrant              store request accepted (combinational pulse)
//   SbBackAble/Ptr       store written, entry pointer to free
//   LdReq*               load request
//   LdGrant              load request accepted (combinational pulse)
//   LdBack*              load data return
//   DcReq*, DcReady      Dcache request / accept
//   DcBackAble/Date      Dcache completion (data valid for reads)
//   DbgState/StarveCnt   observation of FSM state and starvation counter
//
// Handshakes: a request is taken in the cycle its grant is high (SbGrant /
// LdGrant are the ready for SbReqAble / LdReqAble). DcReqAble is held with
// stable fields until the cycle DcReady=1, which is the transfer cycle; a
// DcBackAble is only meaningful while the FSM is in WAIT.
module sb_drain_arbiter
  import sb_drain_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                    Clk,
  input  logic                    Rest,
  input  logic                    ArbFlash,
  input  logic                    SbReqAble,
  input  logic [MAT_W-1:0]        SbReqMat,
  input  logic [SB_PTR_W-1:0]     SbReqPtr,
  input  logic [ADDR_W-1:0]       SbReqAddr,
  input  logic [DATA_W-1:0]       SbReqDate,
  output logic                    SbGrant,
  output logic                    SbBackAble,
  output logic [SB_PTR_W-1:0]     SbBackPtr,
  input  logic                    LdReqAble,
  input  logic [MAT_W-1:0]        LdReqMat,
  input  logic [ADDR_W-1:0]       LdReqAddr,
  input  logic [ROB_PTR_W-1:0]    LdReqRobPtr,
  output logic                    LdGrant,
  output logic                    LdBackAble,
  output logic [DATA_W-1:0]       LdBackDate,
  output logic [ROB_PTR_W-1:0]    LdBackRobPtr,
  output logic                    DcReqAble,
  output logic                    DcReqWrite,
  output logic [MAT_W-1:0]        DcReqMat,
  output logic [ADDR_W-1:0]       DcReqAddr,
  output logic [DATA_W-1:0]       DcReqDate,
  input  logic                    DcReady,
  input  logic                    DcBackAble,
  input  logic [DATA_W-1:0]       DcBackDate,
  output arb_state_e              DbgState,
  output logic [STARVE_CNT_W-1:0] DbgStarveCnt
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

  arb_state_e                state_q, state_d;
  logic [STARVE_CNT_W-1:0]   starve_q, starve_d;
  logic                      killed_q, killed_d;
  logic                      wr_q, wr_d;
  logic [MAT_W-1:0]          mat_q, mat_d;
  logic [SB_PTR_W-1:0]       ptr_q, ptr_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [DATA_W-1:0]         date_q, date_d;
  logic [ROB_PTR_W-1:0]      rob_q, rob_d;
  logic                      st_ok;

  // A drain request with pointer 0 carries no entry and is invisible.
  assign st_ok = SbReqAble && (SbReqPtr != '0);

  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    killed_d     = killed_q;
    wr_d         = wr_q;
    mat_d        = mat_q;
    ptr_d        = ptr_q;
    addr_d       = addr_q;
    date_d       = date_q;
    rob_d        = rob_q;
    SbGrant      = 1'b0;
    SbBackAble   = 1'b0;
    SbBackPtr    = '0;
    LdGrant      = 1'b0;
    LdBackAble   = 1'b0;
    LdBackDate   = '0;
    LdBackRobPtr = '0;
    DcReqAble    = 1'b0;
    DcReqWrite   = 1'b0;
    DcReqMat     = '0;
    DcReqAddr    = '0;
    DcReqDate    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (st_ok && (!LdReqAble || starve_q == STARVE_LIM)) begin
          SbGrant  = 1'b1;
          starve_d = '0;
          wr_d     = 1'b1;
          mat_d    = SbReqMat;
          ptr_d    = SbReqPtr;
          addr_d   = SbReqAddr;
          date_d   = SbReqDate;
          rob_d    = '0;
          state_d  = ST_ISSUE;
        end else if (LdReqAble && !ArbFlash) begin
          LdGrant = 1'b1;
          // Only loads that overtake a waiting drain count toward starvation.
          if (st_ok && starve_q != STARVE_LIM) starve_d = starve_q + STARVE_CNT_W'(1);
          wr_d    = 1'b0;
          mat_d   = LdReqMat;
          ptr_d   = '0;
          addr_d  = LdReqAddr;
          date_d  = '0;
          rob_d   = LdReqRobPtr;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        DcReqAble = 1'b1;
        if (!wr_q && ArbFlash) begin
          // A flushed load already taken by the Dcache must still be
          // drained, so it goes to WAIT marked killed; otherwise drop it.
          if (DcReady) begin
            killed_d = 1'b1;
            state_d  = ST_WAIT;
          end else begin
            DcReqAble = 1'b0;
            killed_d  = 1'b0;
            state_d   = ST_IDLE;
          end
        end else if (DcReady) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!wr_q && ArbFlash) killed_d = 1'b1;
        if (DcBackAble) begin
          if (wr_q) begin
            SbBackAble = 1'b1;
            SbBackPtr  = ptr_q;
          end else if (!killed_q && !ArbFlash) begin
            LdBackAble   = 1'b1;
            LdBackDate   = DcBackDate;
            LdBackRobPtr = rob_q;
          end
          killed_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        killed_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase

    if (DcReqAble) begin
      DcReqWrite = wr_q;
      DcReqMat   = mat_q;
      DcReqAddr  = addr_q;
      DcReqDate  = date_q;
    end

    // Outputs are silent while reset is held, grants included.
    if (!Rest) begin
      SbGrant      = 1'b0;
      SbBackAble   = 1'b0;
      SbBackPtr    = '0;
      LdGrant      = 1'b0;
      LdBackAble   = 1'b0;
      LdBackDate   = '0;
      LdBackRobPtr = '0;
      DcReqAble    = 1'b0;
      DcReqWrite   = 1'b0;
      DcReqMat     = '0;
      DcReqAddr    = '0;
      DcReqDate    = '0;
    end
  end

  assign DbgState     = Rest ? state_q : ST_IDLE;
  assign DbgStarveCnt = Rest ? starve_q : '0;

  always_ff @(posedge Clk) begin
    if (!Rest) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      killed_q <= 1'b0;
      wr_q     <= 1'b0;
      mat_q    <= '0;
      ptr_q    <= '0;
      addr_q   <= '0;
      date_q   <= '0;
      rob_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      killed_q <= killed_d;
      wr_q     <= wr_d;
      mat_q    <= mat_d;
      ptr_q    <= ptr_d;
      addr_q   <= addr_d;
      date_q   <= date_d;
      rob_q    <= rob_d;
    end
  end

endmodule

// File: tb/tb_sb_drain_arbiter.sv
module tb_sb_drain_arbiter;
  import sb_drain_arbiter_pkg::*;

  localparam int STARVE_MAX = 4;
  localparam int VEC_W = 113;

  logic        Clk, Rest, ArbFlash;
  logic        SbReqAble;
  logic [1:0]  SbReqMat;
  logic [2:0]  SbReqPtr;
  logic [31:0] SbReqAddr, SbReqDate;
  logic        SbGrant, SbBackAble;
  logic [2:0]  SbBackPtr;
  logic        LdReqAble;
  logic [1:0]  LdReqMat;
  logic [31:0] LdReqAddr;
  logic [5:0]  LdReqRobPtr;
  logic        LdGrant, LdBackAble;
  logic [31:0] LdBackDate;
  logic [5:0]  LdBackRobPtr;
  logic        DcReqAble, DcReqWrite;
  logic [1:0]  DcReqMat;
  logic [31:0] DcReqAddr, DcReqDate;
  logic        DcReady, DcBackAble;
  logic [31:0] DcBackDate;
  arb_state_e  DbgState;
  logic [2:0]  DbgStarveCnt;

  int checks = 0;
  int failures = 0;

  sb_drain_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .Clk(Clk), .Rest(Rest), .ArbFlash(ArbFlash),
    .SbReqAble(SbReqAble), .SbReqMat(SbReqMat), .SbReqPtr(SbReqPtr),
    .SbReqAddr(SbReqAddr), .SbReqDate(SbReqDate),
    .SbGrant(SbGrant), .SbBackAble(SbBackAble), .SbBackPtr(SbBackPtr),
    .LdReqAble(LdReqAble), .LdReqMat(LdReqMat), .LdReqAddr(LdReqAddr),
    .LdReqRobPtr(LdReqRobPtr),
    .LdGrant(LdGrant), .LdBackAble(LdBackAble), .LdBackDate(LdBackDate),
    .LdBackRobPtr(LdBackRobPtr),
    .DcReqAble(DcReqAble), .DcReqWrite(DcReqWrite), .DcReqMat(DcReqMat),
    .DcReqAddr(DcReqAddr), .DcReqDate(DcReqDate),
    .DcReady(DcReady), .DcBackAble(DcBackAble), .DcBackDate(DcBackDate),
    .DbgState(DbgState), .DbgStarveCnt(DbgStarveCnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic sample();
    @(negedge Clk);
  endtask

  task automatic clear_inputs();
    ArbFlash = 0; SbReqAble = 0; SbReqMat = 0; SbReqPtr = 0; SbReqAddr = 0;
    SbReqDate = 0; LdReqAble = 0; LdReqMat = 0; LdReqAddr = 0; LdReqRobPtr = 0;
    DcReady = 0; DcBackAble = 0; DcBackDate = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] dut_vec();
    return {SbGrant, LdGrant, DcReqAble, DcReqWrite, DcReqMat, DcReqAddr, DcReqDate,
            SbBackAble, SbBackPtr, LdBackAble, LdBackDate, LdBackRobPtr};
  endfunction

  // ---------------- behavioural model + compare ----------------
  // The model tracks one outstanding transaction as a record: whether the
  // port is busy, whether the Dcache has taken the request, its kind and
  // fields, and whether a flush has cancelled it.
  bit          m_busy, m_acc, m_store, m_killed;
  int          m_starve;
  logic [1:0]  m_mat;
  logic [2:0]  m_ptr;
  logic [31:0] m_addr, m_date;
  logic [5:0]  m_rob;

  always @(negedge Clk) begin
    logic e_sg, e_lg, e_dq, e_dw, e_sb, e_lb, st_ok;
    logic [1:0]  e_mat;
    logic [31:0] e_addr, e_dd, e_ld;
    logic [2:0]  e_sp;
    logic [5:0]  e_rob;
    logic [VEC_W-1:0] exp_v, act_v;
    e_sg = 0; e_lg = 0; e_dq = 0; e_dw = 0; e_sb = 0; e_lb = 0;
    e_mat = 0; e_addr = 0; e_dd = 0; e_ld = 0; e_sp = 0; e_rob = 0;
    st_ok = SbReqAble && (SbReqPtr != 0);
    if (Rest) begin
      if (!m_busy) begin
        e_sg = st_ok && (!LdReqAble || m_starve == STARVE_MAX);
        e_lg = !e_sg && LdReqAble && !ArbFlash;
      end else if (!m_acc) begin
        e_dq = !(!m_store && ArbFlash && !DcReady);
        if (e_dq) begin
          e_dw = m_store; e_mat = m_mat; e_addr = m_addr;
          e_dd = m_store ? m_date : 32'h0;
        end
      end else if (DcBackAble) begin
        if (m_store) begin
          e_sb = 1; e_sp = m_ptr;
        end else if (!m_killed && !ArbFlash) begin
          e_lb = 1; e_ld = DcBackDate; e_rob = m_rob;
        end
      end
    end
    exp_v = {e_sg, e_lg, e_dq, e_dw, e_mat, e_addr, e_dd, e_sb, e_sp, e_lb, e_ld, e_rob};
    act_v = dut_vec();
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL model_cycle t=%0t got=%0h exp=%0h", $time, act_v, exp_v);
    end
    // advance the model to the state after the coming rising edge
    if (!Rest) begin
      m_busy = 0; m_acc = 0; m_killed = 0; m_starve = 0;
    end else if (!m_busy) begin
      if (e_sg) begin
        m_busy = 1; m_acc = 0; m_store = 1; m_starve = 0;
        m_mat = SbReqMat; m_ptr = SbReqPtr; m_addr = SbReqAddr; m_date = SbReqDate;
      end else if (e_lg) begin
        m_busy = 1; m_acc = 0; m_store = 0;
        m_mat = LdReqMat; m_addr = LdReqAddr; m_rob = LdReqRobPtr; m_date = SbReqDate;
        if (st_ok && m_starve < STARVE_MAX) m_starve++;
      end
    end else if (!m_acc) begin
      if (!m_store && ArbFlash) begin
        if (DcReady) begin m_acc = 1; m_killed = 1; end
        else m_busy = 0;
      end else if (DcReady) m_acc = 1;
    end else begin
      if (!m_store && ArbFlash) m_killed = 1;
      if (DcBackAble) begin m_busy = 0; m_killed = 0; end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit gs[10];
    int n;
    bit pend;
    Rest = 0;
    clear_inputs();

    // reset: requests pending but everything must stay low
    tick();
    SbReqAble = 1; SbReqPtr = 3; LdReqAble = 1;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("rst_sbgrant", 32'(SbGrant), 0);
      chk("rst_ldgrant", 32'(LdGrant), 0);
      tick();
    end
    clear_inputs();
    Rest = 1;
    tick();

    // store alone
    SbReqAble = 1; SbReqPtr = 3; SbReqAddr = 32'h1000; SbReqDate = 32'hDEAD; SbReqMat = 1;
    sample(); chk("st_grant", 32'(SbGrant), 1);
    tick(); SbReqAble = 0; DcReady = 1;
    sample();
    chk("st_dcreq", 32'(DcReqAble), 1);
    chk("st_dcwrite", 32'(DcReqWrite), 1);
    chk("st_dcaddr", DcReqAddr, 32'h1000);
    chk("st_dcdate", DcReqDate, 32'hDEAD);
    tick(); DcReady = 0;
    sample(); chk("st_wait_noreq", 32'(DcReqAble), 0);
    tick(); DcBackAble = 1;
    sample();
    chk("st_back", 32'(SbBackAble), 1);
    chk("st_backptr", 32'(SbBackPtr), 3);
    tick(); DcBackAble = 0;
    sample(); chk("st_idle", 32'(DbgState), 0);
    tick();

    // contention with zero-latency Dcache
    LdReqAble = 1; LdReqAddr = 32'h2222; LdReqRobPtr = 6'h01;
    SbReqAble = 1; SbReqPtr = 5; SbReqAddr = 32'h5000; SbReqDate = 32'h1234;
    DcReady = 1; DcBackAble = 1; DcBackDate = 32'hCAFE;
    n = 0; pend = 0;
    for (int c = 0; c < 60 && n < 10; c++) begin
      sample();
      if (pend) begin chk("starve_clear", 32'(DbgStarveCnt), 0); pend = 0; end
      if (LdGrant || SbGrant) begin gs[n] = SbGrant; n++; pend = SbGrant; end
      tick();
    end
    chk("cont_count", n, 10);
    for (int i = 0; i < 10; i++) chk("cont_pattern", 32'(gs[i]), 32'((i % 5) == 4));
    LdReqAble = 0; SbReqAble = 0;
    sample();
    if (pend) chk("starve_clear", 32'(DbgStarveCnt), 0);
    tick(); tick(); tick();
    clear_inputs();
    tick();

    // flush during WAIT of a load
    LdReqAble = 1; LdReqAddr = 32'h2000; LdReqRobPtr = 6'h2A; LdReqMat = 2;
    sample(); chk("fl_ldgrant", 32'(LdGrant), 1);
    tick(); LdReqAble = 0; DcReady = 1;
    sample();
    chk("fl_dcreq", 32'(DcReqAble), 1);
    chk("fl_dcwrite", 32'(DcReqWrite), 0);
    chk("fl_dcdate", DcReqDate, 0);
    chk("fl_dcaddr", DcReqAddr, 32'h2000);
    tick(); DcReady = 0; ArbFlash = 1;
    sample(); chk("fl_wait", 32'(DbgState), 32'(ST_WAIT));
    tick(); ArbFlash = 0; DcBackAble = 1; DcBackDate = 32'h55;
    sample(); chk("fl_noback", 32'(LdBackAble), 0);
    tick(); DcBackAble = 0;
    sample(); chk("fl_idle", 32'(DbgState), 0);
    tick();

    // flush while a store waits in ISSUE
    SbReqAble = 1; SbReqPtr = 7; SbReqAddr = 32'h3000; SbReqDate = 32'hBEEF;
    sample(); chk("fs_grant", 32'(SbGrant), 1);
    tick(); SbReqAble = 0;
    sample(); chk("fs_req0", 32'(DcReqAble), 1);
    tick(); ArbFlash = 1;
    sample(); chk("fs_req_flush", 32'(DcReqAble), 1);
    tick(); ArbFlash = 0;
    sample(); chk("fs_req2", 32'(DcReqAble), 1);
    tick(); DcReady = 1;
    sample(); chk("fs_dcdate", DcReqDate, 32'hBEEF);
    tick(); DcReady = 0;
    sample();
    tick(); DcBackAble = 1;
    sample();
    chk("fs_back", 32'(SbBackAble), 1);
    chk("fs_backptr", 32'(SbBackPtr), 7);
    tick(); DcBackAble = 0;

    // invalid pointer, then reset in WAIT
    SbReqAble = 1; SbReqPtr = 0;
    sample(); chk("ptr0_nogrant", 32'(SbGrant), 0);
    tick();
    sample(); chk("ptr0_nogrant2", 32'(SbGrant), 0); chk("ptr0_idle", 32'(DbgState), 0);
    tick(); SbReqAble = 0; LdReqAble = 1; LdReqAddr = 32'h4000; LdReqRobPtr = 6'h11;
    sample(); chk("rw_ldgrant", 32'(LdGrant), 1);
    tick(); LdReqAble = 0; DcReady = 1;
    sample();
    tick(); DcReady = 0; Rest = 0; DcBackAble = 1; DcBackDate = 32'h77;
    sample();
    chk("rw_noback", 32'(LdBackAble), 0);
    chk("rw_outs_zero", 32'(|dut_vec()), 0);
    tick();
    sample(); chk("rw_idle", 32'(DbgState), 0);
    tick(); Rest = 1;
    sample(); chk("rw_ignore_back", 32'(LdBackAble), 0);
    tick(); clear_inputs();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick();
      Rest        = ($urandom_range(0, 79) != 0);
      ArbFlash    = ($urandom_range(0, 5) == 0);
      SbReqAble   = $urandom_range(0, 1);
      SbReqPtr    = 3'($urandom_range(0, 7));
      SbReqMat    = 2'($urandom_range(0, 3));
      SbReqAddr   = $urandom;
      SbReqDate   = $urandom;
      LdReqAble   = $urandom_range(0, 1);
      LdReqMat    = 2'($urandom_range(0, 3));
      LdReqAddr   = $urandom;
      LdReqRobPtr = 6'($urandom_range(0, 63));
      DcReady     = $urandom_range(0, 1);
      DcBackAble  = ($urandom_range(0, 2) == 0);
      DcBackDate  = $urandom;
    end
    tick();
    clear_inputs();
    Rest = 1;
    repeat (3) tick();
    sample();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
